// File: rtl/ram_loader.sv
// ram_loader: host programming front end for the 16-byte data RAM.
// Passes CPU traffic through in RUN; serves host SET_PTR/WRITE/READ when halted.
// Ports:
//   CLK, RESETn        clock, synchronous active-low reset
//   PROG               program-mode request (level)
//   CPU_ADDR/DIN/RI    CPU-side RAM request, passed through in RUN
//   HOST_VALID/CMD/DATA, HOST_READY   host command handshake
//   RB_DATA, RB_VALID  registered readback byte and one-cycle strobe
//   PTR, HALT          load pointer, CPU halt request
//   RAM_ADDR/DIN/RI    to RAM; RAM_DOUT from RAM (one cycle read latency)
module ram_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              PROG,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [DATA_W-1:0] CPU_DIN,
  input  logic              CPU_RI,
  input  logic              HOST_VALID,
  input  logic [1:0]        HOST_CMD,
  input  logic [DATA_W-1:0] HOST_DATA,
  output logic              HOST_READY,
  output logic [DATA_W-1:0] RB_DATA,
  output logic              RB_VALID,
  output logic [ADDR_W-1:0] PTR,
  output logic              HALT,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DIN,
  output logic              RAM_RI,
  input  logic [DATA_W-1:0] RAM_DOUT
);

  typedef enum logic [2:0] {
    RUN,
    P_IDLE,
    P_WRITE,
    P_READ,
    P_RESP
  } state_t;

  localparam logic [1:0] CMD_SET = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_RD  = 2'b11;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] wr_q, wr_d;
  logic [DATA_W-1:0] rb_q, rb_d;
  logic              rbv_q, rbv_d;

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= RUN;
      ptr_q   <= '0;
      wr_q    <= '0;
      rb_q    <= '0;
      rbv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      rb_q    <= rb_d;
      rbv_q   <= rbv_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wr_d       = wr_q;
    rb_d       = rb_q;
    rbv_d      = 1'b0;
    HOST_READY = 1'b0;
    RAM_ADDR   = ptr_q;
    RAM_DIN    = wr_q;
    RAM_RI     = 1'b0;
    unique case (state_q)
      RUN: begin
        RAM_ADDR = CPU_ADDR;
        RAM_DIN  = CPU_DIN;
        RAM_RI   = CPU_RI;
        if (PROG) state_d = P_IDLE;
      end
      P_IDLE: begin
        HOST_READY = PROG;
        if (!PROG) begin
          state_d = RUN;
        end else if (HOST_VALID) begin
          unique case (HOST_CMD)
            CMD_SET: ptr_d = HOST_DATA[ADDR_W-1:0];
            CMD_WR: begin
              wr_d    = HOST_DATA;
              state_d = P_WRITE;
            end
            CMD_RD:  state_d = P_READ;
            default: state_d = P_IDLE;
          endcase
        end
      end
      P_WRITE: begin
        RAM_RI  = 1'b1;
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = P_IDLE;
      end
      P_READ: begin
        state_d = P_RESP;
      end
      P_RESP: begin
        // RAM_DOUT reflects the address presented in P_READ
        rb_d    = RAM_DOUT;
        rbv_d   = 1'b1;
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = P_IDLE;
      end
      default: state_d = RUN;
    endcase
  end

  assign PTR      = ptr_q;
  assign RB_DATA  = rb_q;
  assign RB_VALID = rbv_q;
  assign HALT     = (state_q != RUN);

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: random + directed bench for ram_loader.
// Behavioural model compared every cycle, plus literal checks.
module tb_ram_loader;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       PROG;
  logic [3:0] CPU_ADDR;
  logic [7:0] CPU_DIN;
  logic       CPU_RI;
  logic       HOST_VALID;
  logic [1:0] HOST_CMD;
  logic [7:0] HOST_DATA;
  logic       HOST_READY;
  logic [7:0] RB_DATA;
  logic       RB_VALID;
  logic [3:0] PTR;
  logic       HALT;
  logic [3:0] RAM_ADDR;
  logic [7:0] RAM_DIN;
  logic       RAM_RI;
  logic [7:0] RAM_DOUT;

  ram_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .CLK(CLK), .RESETn(RESETn), .PROG(PROG),
    .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .CPU_RI(CPU_RI),
    .HOST_VALID(HOST_VALID), .HOST_CMD(HOST_CMD),
    .HOST_DATA(HOST_DATA), .HOST_READY(HOST_READY),
    .RB_DATA(RB_DATA), .RB_VALID(RB_VALID), .PTR(PTR), .HALT(HALT),
    .RAM_ADDR(RAM_ADDR), .RAM_DIN(RAM_DIN), .RAM_RI(RAM_RI),
    .RAM_DOUT(RAM_DOUT)
  );

  always #5 CLK = ~CLK;

  // RAM: write on RI, registered read one cycle after address
  logic [7:0] ram [16];
  logic       ram_init = 1'b0;
  always @(posedge CLK) begin
    if (!ram_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      RAM_DOUT <= 8'h00;
    end else begin
      if (RAM_RI === 1'b1) ram[RAM_ADDR] <= RAM_DIN;
      RAM_DOUT <= ram[RAM_ADDR];
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: halted flag, cycles of host op remaining,
  // pointer, write byte, readback and a shadow copy of RAM
  bit         m_halt;
  int         m_busy;
  bit         m_wr_op;
  logic [3:0] m_ptr;
  logic [7:0] m_wr;
  logic [7:0] m_rbd;
  bit         m_rbv;
  logic [7:0] m_mem [16];

  task automatic model_reset();
    m_halt = 0; m_busy = 0; m_wr_op = 0;
    m_ptr = 4'd0; m_rbd = 8'h00; m_rbv = 0;
  endtask

  task automatic model_step();
    bit nrbv;
    if (!m_halt && CPU_RI) m_mem[CPU_ADDR] = CPU_DIN;
    if (m_halt && m_busy > 0 && m_wr_op) m_mem[m_ptr] = m_wr;
    if (!RESETn) begin
      model_reset();
    end else begin
      nrbv = 0;
      if (!m_halt) begin
        m_halt = PROG;
      end else if (m_busy == 0) begin
        if (!PROG) m_halt = 0;
        else if (HOST_VALID) begin
          case (HOST_CMD)
            2'b01: m_ptr = HOST_DATA[3:0];
            2'b10: begin m_wr = HOST_DATA; m_wr_op = 1; m_busy = 1; end
            2'b11: begin m_wr_op = 0; m_busy = 2; end
            default: ;
          endcase
        end
      end else if (m_wr_op) begin
        m_ptr = m_ptr + 4'd1;
        m_busy = 0;
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_rbd = m_mem[m_ptr];
          nrbv = 1;
          m_ptr = m_ptr + 4'd1;
        end
      end
      m_rbv = nrbv;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_wr = 8'h00;
    @(posedge CLK);
    model_reset();
    forever begin
      @(negedge CLK);
      chk("halt", HALT, m_halt);
      chk("rb_valid", RB_VALID, m_rbv);
      chk("rb_data", RB_DATA, m_rbd);
      chk("ptr", PTR, m_ptr);
      if (!m_halt) begin
        chk("run_ready", HOST_READY, 0);
        chk("run_addr", RAM_ADDR, CPU_ADDR);
        chk("run_din", RAM_DIN, CPU_DIN);
        chk("run_ri", RAM_RI, CPU_RI);
      end else if (m_busy == 0) begin
        chk("idle_ready", HOST_READY, PROG);
        chk("idle_ri", RAM_RI, 0);
        chk("idle_addr", RAM_ADDR, m_ptr);
      end else begin
        chk("busy_ready", HOST_READY, 0);
        chk("busy_addr", RAM_ADDR, m_ptr);
        chk("busy_ri", RAM_RI, m_wr_op);
        if (m_wr_op) chk("busy_din", RAM_DIN, m_wr);
      end
      @(posedge CLK);
      model_step();
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // called at posedge+1; returns at posedge+1 of the cycle after accept
  task automatic send(input logic [1:0] c, input logic [7:0] d);
    bit acc;
    acc = 0;
    HOST_VALID = 1'b1; HOST_CMD = c; HOST_DATA = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge CLK);
      acc = HOST_READY;
      tick();
    end
    HOST_VALID = 1'b0;
    chk("accept", acc, 1);
  endtask

  logic [7:0] rexp [3];
  int acc_cnt, ri_cnt;
  logic prev_ri;

  initial begin
    RESETn = 0; PROG = 0; CPU_ADDR = 0; CPU_DIN = 0; CPU_RI = 0;
    HOST_VALID = 0; HOST_CMD = 0; HOST_DATA = 0;
    rexp[0] = 8'hA1; rexp[1] = 8'hB2; rexp[2] = 8'hC3;
    #1;
    repeat (2) tick();
    ram_init = 1'b1;
    @(negedge CLK);
    chk("rst_halt", HALT, 0);
    chk("rst_ready", HOST_READY, 0);
    chk("rst_rbv", RB_VALID, 0);
    chk("rst_ptr", PTR, 0);
    chk("rst_rbd", RB_DATA, 0);
    tick();
    RESETn = 1;
    tick();

    // RUN pass-through
    CPU_ADDR = 4'd5; CPU_DIN = 8'h3C; CPU_RI = 1;
    #1;
    chk("pt_addr", RAM_ADDR, 5);
    chk("pt_din", RAM_DIN, 8'h3C);
    chk("pt_ri", RAM_RI, 1);
    chk("pt_halt", HALT, 0);
    chk("pt_ready", HOST_READY, 0);
    tick();

    // PROG rises; CPU write still passes in the detecting cycle
    PROG = 1; CPU_ADDR = 4'd9; CPU_DIN = 8'h77; CPU_RI = 1;
    #1;
    chk("ri_detect", RAM_RI, 1);
    tick();
    chk("halt_up", HALT, 1);
    chk("ri_blocked", RAM_RI, 0);

    // write with wrap
    send(2'b01, 8'h0E);
    send(2'b10, 8'hA1);
    send(2'b10, 8'hB2);
    send(2'b10, 8'hC3);
    tick();
    chk("ptr_wrap", PTR, 1);
    chk("ram14", ram[14], 8'hA1);
    chk("ram15", ram[15], 8'hB2);
    chk("ram0", ram[0], 8'hC3);

    // readback, RB_VALID three cycles after accept
    send(2'b01, 8'h0E);
    for (int k = 0; k < 3; k++) begin
      send(2'b11, 8'h00);
      @(negedge CLK);
      chk("rd_gap_rbv", RB_VALID, 0);
      chk("rd_gap_ready", HOST_READY, 0);
      tick();
      @(negedge CLK);
      chk("rd_gap_rbv", RB_VALID, 0);
      chk("rd_gap_ready", HOST_READY, 0);
      tick();
      @(negedge CLK);
      chk("rd_rbv", RB_VALID, 1);
      chk("rd_data", RB_DATA, rexp[k]);
      tick();
    end

    // HOST_VALID held with WRITEs, CPU_RI noise
    HOST_VALID = 1; HOST_CMD = 2'b10;
    acc_cnt = 0; ri_cnt = 0; prev_ri = 0;
    for (int i = 0; i < 12; i++) begin
      HOST_DATA = 8'($urandom);
      CPU_RI = 1'($urandom);
      CPU_ADDR = 4'($urandom);
      @(negedge CLK);
      if (HOST_READY) acc_cnt++;
      if (RAM_RI) begin
        ri_cnt++;
        chk("ri_b2b", prev_ri, 0);
      end
      prev_ri = RAM_RI;
      tick();
    end
    HOST_VALID = 0; CPU_RI = 0;
    chk("held_acc", acc_cnt, 6);
    chk("held_ri", ri_cnt, 6);

    // PROG drops during P_READ
    send(2'b01, 8'h09);
    send(2'b11, 8'h00);
    PROG = 0;
    @(negedge CLK);
    chk("drop_halt", HALT, 1);
    tick();
    tick();
    @(negedge CLK);
    chk("drop_rbv", RB_VALID, 1);
    chk("drop_rbd", RB_DATA, 8'h77);
    chk("drop_halt_idle", HALT, 1);
    tick();
    @(negedge CLK);
    chk("drop_run", HALT, 0);
    chk("drop_ptr", PTR, 10);
    tick();
    PROG = 1;
    tick();
    tick();
    chk("resume_ptr", PTR, 10);
    chk("resume_halt", HALT, 1);

    // reset during P_WRITE
    send(2'b10, 8'h5A);
    RESETn = 0; PROG = 0; CPU_RI = 0;
    @(negedge CLK);
    chk("rstw_ri", RAM_RI, 1);
    tick();
    RESETn = 1;
    @(negedge CLK);
    chk("rstw_halt", HALT, 0);
    chk("rstw_ptr", PTR, 0);
    chk("rstw_rbv", RB_VALID, 0);
    chk("rstw_ri_off", RAM_RI, 0);
    chk("rstw_ram", ram[10], 8'h5A);
    tick();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      RESETn = ($urandom_range(0, 99) != 0);
      PROG = ($urandom_range(0, 9) != 0);
      HOST_VALID = 1'($urandom);
      HOST_CMD = 2'($urandom);
      HOST_DATA = 8'($urandom);
      CPU_ADDR = 4'($urandom);
      CPU_DIN = 8'($urandom);
      CPU_RI = 1'($urandom);
      tick();
    end
    RESETn = 1; HOST_VALID = 0; PROG = 0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
